// File: rtl/sft_reg_pkg.sv
// ---------------------------------------------------------------------------
// sft_reg_pkg
// Shared definitions for the shift-register frame serializer.
//   DEF_WIDTH : default parallel word width
//   state_e   : controller state encoding (IDLE/SHIFT/PAR/DONE)
// S_PAR is only reachable when SFT_REG_CTRL_PARITY_EN is defined.
// ---------------------------------------------------------------------------
package sft_reg_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/piso_sft_core.sv
// ---------------------------------------------------------------------------
// piso_sft_core
// Parallel-in / serial-out shift register.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, clears the register
//   load_i  : load data_i into the register (has priority over shift_i)
//   shift_i : shift one position toward the output end, zero-filled
//   dir_i   : 0 = MSB is the output end, 1 = LSB is the output end
//   data_i  : parallel word
//   ser_o   : bit currently at the output end
// ---------------------------------------------------------------------------
module piso_sft_core
  import sft_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      if (dir_i) begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_o = dir_i ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/sft_reg_ctrl.sv
// ---------------------------------------------------------------------------
// sft_reg_ctrl
// Frame serializer: accepts a parallel word over valid/ready and emits it one
// bit per clock, then pulses done for one cycle.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : producer presents a word on pin
//   in_ready   : controller can accept a word this cycle (IDLE only)
//   pin        : parallel word
//   lsb_first  : bit order, sampled only at accept
//   sout       : serial data bit
//   sout_valid : sout carries a frame bit this cycle
//   busy       : frame in progress (state != IDLE)
//   done       : one-cycle pulse after the last frame bit
// Handshake: a word transfers at a rising edge where in_valid && in_ready are
// both high; in_valid while in_ready is low is ignored, and the producer holds
// its word until it is taken.
// Build option: SFT_REG_CTRL_PARITY_EN appends an even-parity bit (XOR of the
// accepted word) after the data bits.
// All outputs are decoded from registered state, so reset drives them to their
// idle values without waiting for a clock.
// ---------------------------------------------------------------------------
module sft_reg_ctrl
  import sft_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pin,
  input  logic             lsb_first,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             order_q, order_d;
  logic             load, shift_en, core_bit;

`ifdef SFT_REG_CTRL_PARITY_EN
  logic parity_q, parity_d;
`endif

  piso_sft_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift_en),
    .dir_i   (order_q),
    .data_i  (pin),
    .ser_o   (core_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    order_d    = order_q;
    load       = 1'b0;
    shift_en   = 1'b0;
    in_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
`ifdef SFT_REG_CTRL_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load    = 1'b1;
          order_d = lsb_first;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SFT_REG_CTRL_PARITY_EN
          parity_d = ^pin;
`endif
        end
      end
      S_SHIFT: begin
        sout_valid = 1'b1;
        sout       = core_bit;
        shift_en   = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Clear rather than increment so cnt never passes WIDTH-1.
          cnt_d = '0;
`ifdef SFT_REG_CTRL_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAR: begin
`ifdef SFT_REG_CTRL_PARITY_EN
        sout_valid = 1'b1;
        sout       = parity_q;
        state_d    = S_DONE;
`else
        state_d    = S_IDLE;
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
    end
  end

`ifdef SFT_REG_CTRL_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: doc/sft_reg_ctrl.md
Name: sft_reg_ctrl

Overview:
Controller that sequences a parallel-in shift register as a frame serializer for the 4-bit shift-register datapath family.
- Upstream side: accepts a parallel word through a valid/ready handshake.
- Downstream side: drives load and shift of the internal register and emits the word one bit per clock with a serial valid strobe, then pulses completion.
- Sits between a parallel producer (e.g. register file or test pattern source) and a serial link.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst==0 clears all state immediately)
in_valid  input  1  producer presents a word on pin
in_ready  output  1  controller can accept a word this cycle
pin  input  WIDTH  parallel word
lsb_first  input  1  bit order for the frame; sampled only at accept
sout  output  1  serial data bit
sout_valid  output  1  sout carries a valid frame bit this cycle
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse after last frame bit

Behaviour:
- States: IDLE, SHIFT, PAR (exists only with PARITY_EN), DONE. State is registered.
- Reset values (rst==0, async): state=IDLE, shreg=0, cnt=0, order flag=0, in_ready=1, sout=0, sout_valid=0, busy=0, done=0.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid&&in_ready at a rising edge. On accept: shreg<=pin, order<=lsb_first, cnt<=0, next=SHIFT.
  - No accept: stay in IDLE.
- SHIFT:
  - in_ready=0, sout_valid=1.
  - sout = shreg[WIDTH-1] if order==0 (MSB first); sout = shreg[0] if order==1.
  - Each edge: shreg shifts toward the output end, zero-filled; cnt<=cnt+1.
  - When cnt==WIDTH-1: next=PAR if PARITY_EN is defined, else DONE.
- PAR: see Optional Feature.
- DONE:
  - done=1, sout_valid=0, in_ready=0, sout=0.
  - next=IDLE unconditionally.
- Latency, accept at edge k:
  - frame bits valid in cycles k+1..k+WIDTH;
  - done high in cycle k+WIDTH+1 (k+WIDTH+2 with parity);
  - in_ready high again the cycle after done.
  - Frame-to-frame period: WIDTH+2 cycles (WIDTH+3 with parity).
- Outside SHIFT/PAR: sout=0 and sout_valid=0.
- busy=1 in every state except IDLE.
- in_valid while in_ready=0: ignored, no side effects. The producer must hold its word until accepted.
- lsb_first or pin changing mid-frame: no effect on the frame in flight.
- Reset asserted mid-frame: frame abandoned immediately, no done pulse, outputs return to reset values asynchronously.
- Reset released: the first accept can occur at the first rising edge with rst==1.
- cnt never exceeds WIDTH-1; it has no wrap-around path.

Optional Feature:
Macro SFT_REG_CTRL_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the accepted word) is latched at accept.
  - After the last data bit, state PAR drives sout=parity and sout_valid=1 for one cycle, then goes to DONE.
- Undefined:
  - PAR state and parity register are absent.
  - SHIFT goes directly to DONE; timing is as stated for the non-parity case.

Decomposition:
- Package sft_reg_pkg: state enum typedef (IDLE/SHIFT/PAR/DONE), localparam DEF_WIDTH=4.
- One sub-module, piso_sft_core: holds shreg with load, shift-enable and direction inputs, plus the serial output bit.
- FSM, counter and handshake stay in sft_reg_ctrl.

Test Plan:
- WIDTH=4, pin=4'b1010, lsb_first=0, one-cycle in_valid from IDLE -> sout 1,0,1,0 with sout_valid=1 for 4 cycles, then done=1 for 1 cycle, then in_ready=1.
- pin=4'b1100, lsb_first=1 -> sout 0,0,1,1; toggling lsb_first to 0 in cycle 2 of the frame -> sequence unchanged.
- in_valid held high with pin=4'b1111 while busy after accepting 4'b1010 -> first frame 1,0,1,0 unaltered; 4'b1111 accepted only when in_ready returns, serialized as 1,1,1,1.
- rst driven 0 during 2nd shift cycle -> sout=0, sout_valid=0, busy=0, in_ready=1 without waiting for a clock; no done pulse; new frame 4'b0110 after release serializes correctly.
- Back-to-back frames 4'b1001 and 4'b0101 with in_valid continuously high -> accepts exactly WIDTH+2=6 cycles apart, bits 1,0,0,1 then 0,1,0,1.
- With SFT_REG_CTRL_PARITY_EN, pin=4'b1011 -> sout 1,0,1,1 then parity bit 1 with sout_valid=1; done one cycle later. pin=4'b0110 -> parity bit 0.
